// File: rtl/fog_tx_pkg.sv
// Shared definitions for the FOG packet UART transmitter: header defaults,
// packet geometry, packet FSM states and the CRC-8 (poly 0x07) byte step.
package fog_tx_pkg;

    localparam int          BAUD_DIV_DEF  = 868;
    localparam logic [7:0]  HDR0_DEF      = 8'hC1;
    localparam logic [7:0]  HDR1_DEF      = 8'hC2;
    localparam int          PKT_BYTES     = 15;
    localparam int          PAYLOAD_BYTES = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } tx_state_t;

    // One byte of CRC-8, polynomial 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fog_pkt_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser. A byte is accepted when valid & ready;
// ready rises in the last cycle of the stop bit so bytes go out back to back.
// tick marks the last cycle of every bit period.
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       valid,
    output logic       ready,
    output logic       tick,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic          active_reg;

    assign tick  = active_reg && (baud_cnt_reg == CW'(BAUD_DIV - 1));
    assign ready = !active_reg || (tick && (bit_cnt_reg == 4'd9));
    // Line is driven straight from the shifter LSB, so it is always a flop output.
    assign tx    = shift_reg[0];

    // Baud counter and shifter; idle shifter is all ones (line high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '1;
            active_reg   <= 1'b0;
        end else if (valid && ready) begin
            shift_reg    <= {1'b1, byte_in, 1'b0};
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (tick) begin
                shift_reg    <= {1'b1, shift_reg[9:1]};
                baud_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg <= 1'b0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fog_pkt_uart_tx.sv
// fog_pkt_uart_tx: frames a snapshot of (error, step, ramp) into a 15-byte
// packet HDR0 HDR1 payload[12] CHK on a UART line.
// Build option FOG_TX_CRC_EN: CHK is CRC-8/0x07 instead of the modulo-256 sum.
module fog_pkt_uart_tx
    import fog_tx_pkg::*;
#(
    parameter int         BAUD_DIV = BAUD_DIV_DEF,
    parameter logic [7:0] HDR0     = HDR0_DEF,
    parameter logic [7:0] HDR1     = HDR1_DEF
) (
    input  logic        CLOCK_CPU,
    input  logic        RST_SYNC_N,
    input  logic        i_en,
    input  logic        i_trig,
    input  logic [31:0] i_err,
    input  logic [31:0] i_step,
    input  logic [31:0] i_ramp,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_drop,
    output logic [15:0] o_pkt_cnt
);

    tx_state_t   state_reg, state_next;
    logic [3:0]  byte_idx_reg;
    logic [2:0]  bit_idx_reg;
    logic [95:0] snap_reg;
    logic [7:0]  chk_reg;
    logic        busy_reg;
    logic        drop_reg;
    logic [15:0] pkt_cnt_reg;

    logic        accept, load, tick, ready;
    logic [3:0]  next_idx;
    logic [95:0] snap_shift;
    logic [7:0]  payload_byte, byte_sel, chk_next;

    assign accept = i_trig && i_en && (state_reg == ST_IDLE);

    // Byte to load next: header 0 on accept, otherwise the following index.
    assign next_idx     = (state_reg == ST_IDLE) ? 4'd0 : byte_idx_reg + 4'd1;
    assign snap_shift   = snap_reg >> {4'd13 - next_idx, 3'b000};
    assign payload_byte = snap_shift[7:0];

`ifdef FOG_TX_CRC_EN
    assign chk_next = crc8_byte(chk_reg, payload_byte);
`else
    assign chk_next = chk_reg + payload_byte;
`endif

    // Byte mux for the serialiser.
    always_comb begin
        byte_sel = payload_byte;
        case (next_idx)
            4'd0:                    byte_sel = HDR0;
            4'd1:                    byte_sel = HDR1;
            4'(PKT_BYTES - 1):       byte_sel = chk_reg;
            default:                 byte_sel = payload_byte;
        endcase
    end

    // Packet FSM next state; load requests the next byte into the serialiser.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE:  if (accept) begin
                          load       = 1'b1;
                          state_next = ST_START;
                      end
            ST_START: if (tick) state_next = ST_DATA;
            ST_DATA:  if (tick && (bit_idx_reg == 3'd7)) state_next = ST_STOP;
            ST_STOP:  if (ready) begin
                          if (byte_idx_reg == 4'(PKT_BYTES - 1)) begin
                              state_next = ST_DONE;
                          end else begin
                              load       = 1'b1;
                              state_next = ST_START;
                          end
                      end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM state and per-bit position inside the data field.
    always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
        if (!RST_SYNC_N) begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg != ST_DATA) bit_idx_reg <= '0;
            else if (tick)            bit_idx_reg <= bit_idx_reg + 3'd1;
        end
    end

    // Snapshot, byte index and checksum; the check byte accumulates as payload is loaded.
    always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
        if (!RST_SYNC_N) begin
            snap_reg     <= '0;
            byte_idx_reg <= '0;
            chk_reg      <= '0;
        end else if (accept) begin
            snap_reg     <= {i_err, i_step, i_ramp};
            byte_idx_reg <= '0;
            chk_reg      <= '0;
        end else if (load) begin
            byte_idx_reg <= next_idx;
            if (next_idx >= 4'd2 && next_idx <= 4'(PAYLOAD_BYTES + 1)) chk_reg <= chk_next;
        end
    end

    // Status: busy spans exactly the bits on the line, drop flags refused triggers.
    always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
        if (!RST_SYNC_N) begin
            busy_reg    <= 1'b0;
            drop_reg    <= 1'b0;
            pkt_cnt_reg <= '0;
        end else begin
            drop_reg <= i_trig && i_en && (state_reg != ST_IDLE);
            if (accept)                                            busy_reg <= 1'b1;
            else if (state_reg == ST_STOP && state_next == ST_DONE) busy_reg <= 1'b0;
            if (state_reg == ST_DONE) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk     (CLOCK_CPU),
        .rst_n   (RST_SYNC_N),
        .byte_in (byte_sel),
        .valid   (load),
        .ready   (ready),
        .tick    (tick),
        .tx      (o_tx)
    );

    assign o_busy    = busy_reg;
    assign o_drop    = drop_reg;
    assign o_pkt_cnt = pkt_cnt_reg;

endmodule

// File: tb/tb_fog_pkt_uart_tx.sv
// Bench for fog_pkt_uart_tx at BAUD_DIV=4: a packet-level model predicts the
// line, busy, drop and counter every cycle; literal expectations pin the model.
module tb_fog_pkt_uart_tx;

    localparam int BD      = 4;
    localparam int PKT_CYC = 150 * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        trig = 1'b0;
    logic [31:0] err = '0, step = '0, ramp = '0;
    logic        tx, busy, drop;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fog_pkt_uart_tx #(.BAUD_DIV(BD), .HDR0(8'hC1), .HDR1(8'hC2)) dut (
        .CLOCK_CPU  (clk),
        .RST_SYNC_N (rst_n),
        .i_en       (en),
        .i_trig     (trig),
        .i_err      (err),
        .i_step     (step),
        .i_ramp     (ramp),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_drop     (drop),
        .o_pkt_cnt  (pkt_cnt)
    );

    // ---------------- model ----------------
    int          m_pos = 0;          // cycle number within packet, 0 = idle, 601 = wrap-up cycle
    logic        m_drop = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [7:0]  m_bytes [15];
    logic        m_bits  [150];
    logic        line_log [0:PKT_CYC];
    int          drop_seen = 0;
    int          fall_pos = 0;
    logic        busy_prev = 1'b0;

    logic [7:0] gold [15] = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34,
                              8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11};

    function automatic logic [7:0] model_chk(input logic [95:0] p);
        logic [7:0] acc;
        logic       fb;
        acc = 8'h00;
`ifdef FOG_TX_CRC_EN
        for (int i = 95; i >= 0; i--) begin
            fb  = acc[7] ^ p[i];
            acc = {acc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
`else
        fb = 1'b0;
        for (int i = 0; i < 12; i++) acc = acc + 8'(p >> (88 - 8 * i));
`endif
        return acc;
    endfunction

    task automatic build(input logic [31:0] e, input logic [31:0] s, input logic [31:0] r);
        logic [95:0] p;
        p = {e, s, r};
        m_bytes[0] = 8'hC1;
        m_bytes[1] = 8'hC2;
        for (int i = 0; i < 12; i++) m_bytes[2 + i] = 8'(p >> (88 - 8 * i));
        m_bytes[14] = model_chk(p);
        for (int i = 0; i < 15; i++) begin
            m_bits[10 * i] = 1'b0;
            for (int j = 0; j < 8; j++) m_bits[10 * i + 1 + j] = m_bytes[i][j];
            m_bits[10 * i + 9] = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pos  = 0;
            m_drop = 1'b0;
            m_cnt  = '0;
        end else begin
            m_drop = trig && en && (m_pos != 0);
            if (m_pos == PKT_CYC + 1) begin
                m_pos = 0;
                m_cnt = m_cnt + 16'd1;
            end else if (m_pos != 0) begin
                m_pos++;
            end else if (trig && en) begin
                build(err, step, ramp);
                m_pos = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    initial forever begin
        logic exp_tx;
        @(negedge clk);
        if (rst_n) begin
            exp_tx = (m_pos >= 1 && m_pos <= PKT_CYC) ? m_bits[(m_pos - 1) / BD] : 1'b1;
            chk("tx",      32'(tx),      32'(exp_tx));
            chk("busy",    32'(busy),    32'(m_pos >= 1 && m_pos <= PKT_CYC));
            chk("drop",    32'(drop),    32'(m_drop));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
            if (m_pos >= 1 && m_pos <= PKT_CYC) line_log[m_pos] = tx;
            if (drop) drop_seen++;
            if (busy_prev && !busy) fall_pos = m_pos;
            busy_prev = busy;
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse();
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_pos == p) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos: position %0d never reached", p);
    endtask

    function automatic logic [7:0] line_byte(input int i);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = line_log[(10 * i + 1 + j) * BD + 2];
        return b;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx",   32'(tx),      32'd1);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_drop", 32'(drop),    32'd0);
        chk("rst_cnt",  32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // trigger with enable low is ignored
        en = 1'b0;
        pulse();
        repeat (10) @(negedge clk);
        chk("dis_tx",   32'(tx),   32'd1);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_drop", 32'(drop_seen), 32'd0);

        // reference packet; inputs and enable change right after accept
        err = 32'h00000001; step = 32'h12345678; ramp = 32'hFFFFFFFF; en = 1'b1;
        pulse();
        err = 32'hDEADBEEF; step = 32'h0; ramp = 32'h55AA55AA; en = 1'b0;
        repeat (PKT_CYC + 5) @(negedge clk);
        chk("start_bit", 32'({line_log[1], line_log[2], line_log[3], line_log[4], line_log[5]}), 32'b00001);
        for (int i = 0; i < 14; i++) chk($sformatf("ref_byte%0d", i), 32'(line_byte(i)), 32'(gold[i]));
`ifdef FOG_TX_CRC_EN
        chk("ref_crc", 32'(line_byte(14)), 32'(model_chk({32'h00000001, 32'h12345678, 32'hFFFFFFFF})));
`else
        chk("ref_sum",       32'(line_byte(14)), 32'h11);
        chk("model_sum_lit", 32'(m_bytes[14]),  32'h11);
`endif
        chk("ref_cnt", 32'(pkt_cnt), 32'd1);

        // second trigger mid-packet and one during the wrap-up cycle are dropped
        en = 1'b1; err = 32'h80000000; step = 32'h7FFFFFFF; ramp = 32'h01020304;
        drop_seen = 0;
        pulse();
        repeat (98) @(negedge clk);
        pulse();
        wait_pos(PKT_CYC + 1);
        trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_count", 32'(drop_seen), 32'd2);
        chk("busy_fall",  32'(fall_pos),  32'd601);
        chk("drop_cnt",   32'(pkt_cnt),   32'd2);
        chk("drop_idle",  32'(busy),      32'd0);

        // reset asserted during byte 6 aborts immediately
        err = 32'hCAFEF00D; step = 32'h0BADC0DE; ramp = 32'h00000080;
        pulse();
        wait_pos(220);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx",   32'(tx),   32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        err = 32'hA5A5A5A5; step = 32'hFEDCBA98; ramp = 32'h13579BDF;
        pulse();
        repeat (PKT_CYC + 5) @(negedge clk);
        chk("clean_b2",  32'(line_byte(2)),  32'hA5);
        chk("clean_b9",  32'(line_byte(9)),  32'h98);
        chk("clean_b13", 32'(line_byte(13)), 32'hDF);
        chk("clean_cnt", 32'(pkt_cnt), 32'd1);

        // counter wrap
        @(posedge clk);
        #1;
        force dut.pkt_cnt_reg = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt_reg;
        @(negedge clk);
        chk("wrap_pre", 32'(pkt_cnt), 32'hFFFF);
        pulse();
        repeat (PKT_CYC + 5) @(negedge clk);
        chk("wrap_post", 32'(pkt_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
